// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: glyph table, glyph lookup and scan timing helper for the seven-segment controller
package sevenseg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h7E;
  localparam logic [6:0] GLYPHS [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };
  function automatic logic [6:0] glyph(input logic [3:0] nibble, input logic hex_mode);
    return (hex_mode || nibble < 4'hA) ? GLYPHS[nibble] : nibble == 4'hA ? SEG_DASH : SEG_BLANK;
  endfunction
  function automatic int sub_div(input int clk_hz, input int scan_hz);
    return clk_hz / (scan_hz * 8);
  endfunction
endpackage

// File: rtl/sevenseg_lz_mask.sv
// sevenseg_lz_mask: blanks digits 1..N-1 that sit above the most significant nonzero digit
module sevenseg_lz_mask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*(NUM_DIGITS-1)-1:0] hi_digits,
  input  logic                        lz_blank,
  output logic [NUM_DIGITS-1:0]       blank
);
  logic [NUM_DIGITS:1] zero_above;
  assign zero_above[NUM_DIGITS] = 1'b1;
  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_z
    assign zero_above[i] = zero_above[i+1] & (hi_digits[4*(i-1) +: 4] == 4'd0);
  end
  assign blank = lz_blank ? {zero_above[NUM_DIGITS-1:1], 1'b0} : '0;
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed common-anode seven-segment driver with per-frame input snapshot,
// leading-zero blanking, per-digit blink and 8-level PWM brightness
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 4000,
  parameter int BLINK_FRAMES = 250,
  parameter bit HEX_MODE     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  input  logic [2:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);
  localparam int SUB_DIV = sub_div(CLK_HZ, SCAN_HZ);
  localparam int PW = SUB_DIV > 1 ? $clog2(SUB_DIV) : 1;
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam int SNAP_W = 6 * NUM_DIGITS + 4;

  if (SUB_DIV < 2) begin : g_sub_div_check
    $error("sevenseg_scan_ctrl: CLK_HZ/(SCAN_HZ*8) must be at least 2");
  end

  logic [PW-1:0]           pre_q, pre_d;
  logic [2:0]              phase_q, phase_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic                    blink_q, blink_d;
  logic [SNAP_W-1:0]       snap_q, snap_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d, fs_q, fs_d;
  logic                    tick, slot_end, frame_end, lit;
  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_bm, lz_mask;
  logic                    sh_lz;
  logic [2:0]              sh_br;

  assign {sh_digits, sh_dp, sh_bm, sh_lz, sh_br} = snap_q;

  sevenseg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz (
    .hi_digits(sh_digits[4*NUM_DIGITS-1:4]),
    .lz_blank (sh_lz),
    .blank    (lz_mask)
  );

  always_comb begin
    tick = en && pre_q == PW'(SUB_DIV - 1);
    slot_end = tick && phase_q == 3'd7;
    frame_end = slot_end && sel_q == SW'(NUM_DIGITS - 1);
    pre_d = tick ? '0 : en ? pre_q + 1'b1 : pre_q;
    phase_d = tick ? phase_q + 3'd1 : phase_q;
    sel_d = frame_end ? '0 : slot_end ? sel_q + 1'b1 : sel_q;
    frame_d = !frame_end ? frame_q : frame_q == FW'(BLINK_FRAMES - 1) ? '0 : frame_q + 1'b1;
    blink_d = blink_q ^ (frame_end && frame_q == FW'(BLINK_FRAMES - 1));
    snap_d = frame_end ? {digits, dp_in, blink_mask, lz_blank, brightness} : snap_q;
    // phase 0 is the anti-ghost dead slot; lit phases run 1..brightness
    lit = en && phase_q != 3'd0 && phase_q <= sh_br && !(sh_bm[sel_q] && blink_q);
    an_d = lit ? ~(NUM_DIGITS'(1) << sel_q) : '1;
    seg_d = (!lit || lz_mask[sel_q]) ? SEG_BLANK : glyph(sh_digits[4*sel_q +: 4], HEX_MODE);
    dp_d = !(lit && sh_dp[sel_q]);
    fs_d = en && pre_q == '0 && phase_q == 3'd0 && sel_q == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      phase_q <= '0;
      sel_q <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      snap_q <= '0;
      an_q <= '1;
      seg_q <= SEG_BLANK;
      dp_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      phase_q <= phase_d;
      sel_q <= sel_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      snap_q <= snap_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      fs_q <= fs_d;
    end
  end

  assign an = an_q;
  assign seg = seg_q;
  assign dp = dp_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: scoreboard bench for decimal and hex instances of sevenseg_scan_ctrl
module tb_sevenseg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n, en, lz_blank;
  logic [15:0] digits;
  logic [3:0] dp_in, blink_mask;
  logic [2:0] brightness;
  logic [3:0] an, an_h;
  logic [6:0] seg, seg_h;
  logic dp, dp_h, frame_start, frame_start_h;
  int checks = 0, failures = 0;
  int c, lit_cnt, d0_cnt, d1_cnt, fs_cnt, ph0_lit;
  logic [15:0] sh_dig;
  logic [3:0] sh_dp, sh_bm;
  logic sh_lz;
  logic [2:0] sh_br;
  logic [19:0] sb[$];
  logic [11:0] obs[4];
  logic [6:0] obs_h[4];
  int bl_exp[4] = '{0, 28, 28, 0};
  logic [6:0] hex_tab[16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  logic [6:0] dec_tab[16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h7E, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.NUM_DIGITS(4), .CLK_HZ(64), .SCAN_HZ(2), .BLINK_FRAMES(2), .HEX_MODE(1'b0)) u_dec (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in), .blink_mask(blink_mask),
    .lz_blank(lz_blank), .brightness(brightness), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );
  sevenseg_scan_ctrl #(.NUM_DIGITS(4), .CLK_HZ(64), .SCAN_HZ(2), .BLINK_FRAMES(2), .HEX_MODE(1'b1)) u_hex (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in), .blink_mask(blink_mask),
    .lz_blank(lz_blank), .brightness(brightness), .an(an_h), .seg(seg_h), .dp(dp_h), .frame_start(frame_start_h)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // oc counts enabled clocks since reset: 4 per phase, 32 per slot, 128 per frame
  function automatic logic [19:0] expect_out(input int oc);
    int ph, s;
    logic blk, on, lzb, fs;
    logic [3:0] nib;
    ph = (oc / 4) % 8;
    s = (oc / 32) % 4;
    blk = ((oc / 128) / 2) % 2 == 1;
    on = en && ph >= 1 && ph <= int'(sh_br) && !(sh_bm[s] && blk);
    lzb = sh_lz && s >= 1 && (sh_dig >> (4 * s)) == 16'd0;
    nib = sh_dig[4 * s +: 4];
    fs = en && oc % 128 == 0;
    if (!on) return {fs, 4'hF, 1'b1, 7'h7F, 7'h7F};
    return {fs, ~(4'b0001 << s), ~sh_dp[s], lzb ? 7'h7F : dec_tab[nib], lzb ? 7'h7F : hex_tab[nib]};
  endfunction

  task automatic cyc();
    logic [19:0] e;
    int oc;
    oc = c;
    sb.push_back(expect_out(oc));
    if (en) begin
      if (c % 128 == 127) {sh_dig, sh_dp, sh_bm, sh_lz, sh_br} = {digits, dp_in, blink_mask, lz_blank, brightness};
      c++;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("dec", {frame_start, an, dp, seg}, e[19:7]);
    check("hex", {frame_start_h, an_h, dp_h, seg_h}, {e[19:14], e[6:0]});
    if (an != 4'hF) lit_cnt++;
    if (an == 4'b1110) d0_cnt++;
    if (an == 4'b1101) d1_cnt++;
    if (frame_start) fs_cnt++;
    if (oc % 32 < 4 && an != 4'hF) ph0_lit++;
    if (oc % 32 == 16) begin
      obs[(oc / 32) % 4] = {an, dp, seg};
      obs_h[(oc / 32) % 4] = seg_h;
    end
  endtask

  task automatic frames(input int n);
    repeat (n * 128) cyc();
  endtask

  task automatic model_reset();
    c = 0;
    {sh_dig, sh_dp, sh_bm, sh_lz, sh_br} = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; digits = 16'h1234; dp_in = 4'b0; blink_mask = 4'b0;
    lz_blank = 1'b0; brightness = 3'd7; ph0_lit = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_fs", frame_start, 1'b0);
    en = 1'b1;
    rst_n = 1'b1;
    lit_cnt = 0;
    frames(1);
    check("f1_dark", lit_cnt, 0);
    d0_cnt = 0;
    repeat (32) cyc();
    check("f2_d0_lit", d0_cnt, 28);
    check("f2_d0_glyph", obs[0], {4'b1110, 1'b1, 7'h4C});
    repeat (96) cyc();
    brightness = 3'd3;
    frames(1);
    lit_cnt = 0; d0_cnt = 0;
    frames(1);
    check("b3_lit", lit_cnt, 48);
    check("b3_d0", d0_cnt, 12);
    brightness = 3'd0;
    frames(1);
    lit_cnt = 0;
    frames(1);
    check("b0_dark", lit_cnt, 0);
    brightness = 3'd7; digits = 16'h0070; lz_blank = 1'b1; dp_in = 4'b1000;
    frames(2);
    check("lz_d3", obs[3], {4'b0111, 1'b0, 7'h7F});
    check("lz_d2", obs[2], {4'b1011, 1'b1, 7'h7F});
    check("lz_d1", obs[1], {4'b1101, 1'b1, 7'h0F});
    check("lz_d0", obs[0], {4'b1110, 1'b1, 7'h01});
    digits = 16'h00CA; lz_blank = 1'b0; dp_in = 4'b0;
    frames(2);
    check("dec_dash", obs[0][6:0], 7'h7E);
    check("dec_c_blank", obs[1][6:0], 7'h7F);
    check("hex_a", obs_h[0], 7'h08);
    check("hex_c", obs_h[1], 7'h31);
    digits = 16'h1234; blink_mask = 4'b0001;
    frames(1);
    for (int f = 0; f < 4; f++) begin
      d0_cnt = 0; d1_cnt = 0;
      frames(1);
      check("blink_d0", d0_cnt, bl_exp[f]);
      check("blink_d1", d1_cnt, 28);
    end
    repeat (20) cyc();
    en = 1'b0; lit_cnt = 0; fs_cnt = 0;
    repeat (50) cyc();
    check("enlow_dark", lit_cnt, 0);
    check("enlow_fs", fs_cnt, 0);
    en = 1'b1; fs_cnt = 0;
    repeat (108) cyc();
    check("resume_no_fs", fs_cnt, 0);
    cyc();
    check("resume_fs", fs_cnt, 1);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(((c - 1) % 32) / 4 == 3 && ((c - 1) / 32) % 4 == 1) && n < 300);
    check("seek_bound", n < 300, 1'b1);
    check("pre_rst_lit", an, 4'b1101);
    rst_n = 1'b0;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 7'h7F);
    check("arst_dp", dp, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_an", an, 4'hF);
    rst_n = 1'b1; lit_cnt = 0; fs_cnt = 0;
    frames(1);
    check("post_rst_dark", lit_cnt, 0);
    check("post_rst_fs", fs_cnt, 1);
    check("ph0_dark", ph0_lit, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Parametrised, time-multiplexed seven-segment display controller, the next generation of the team's scan mux. It generates its own scan timing from the system clock and drives N common-anode digits. Features: hex or decimal glyphs, per-digit decimal points, leading-zero blanking, per-digit blink and 8-level PWM brightness. Sits between score/timer logic and the board's `an`/`seg`/`dp` pins; all inputs are snapshotted once per frame so the display never tears.

## Interface
- `NUM_DIGITS`, 4: digits scanned, 2..8.
- `CLK_HZ`, 100_000_000: clk frequency.
- `SCAN_HZ`, 4000: digit-slot rate. Frame rate is SCAN_HZ/NUM_DIGITS.
- `BLINK_FRAMES`, 250: frames per blink half-period; ≥1.
- `HEX_MODE`, 0: 1 = glyphs 0–F; 0 = 0–9, 0xA shows '-' (g only), 0xB–0xF blank.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: scan enable. Low freezes all counters and forces the display dark.
- `digits` in 4*NUM_DIGITS: nibble i = digit i; digit 0 is least significant.
- `dp_in` in NUM_DIGITS: decimal point per digit, 1 = lit.
- `blink_mask` in NUM_DIGITS: 1 = digit blinks.
- `lz_blank` in 1: enables leading-zero blanking.
- `brightness` in 3: 0 = off, 7 = maximum.
- `an` out NUM_DIGITS: digit enables, active-low.
- `seg` out 7: {a,b,c,d,e,f,g}, active-low.
- `dp` out 1: decimal point, active-low.
- `frame_start` out 1: one-cycle pulse at each frame boundary.

## Operation
- `SUB_DIV = CLK_HZ/(SCAN_HZ*8)`, integer division. Elaboration fails if SUB_DIV < 2.
- Prescaler counts 0..SUB_DIV-1. `tick` asserts when prescaler == SUB_DIV-1 and en = 1.
- `phase` (3 b) increments on tick and wraps 7→0.
- `sel` increments when phase wraps and wraps NUM_DIGITS-1→0.
- Frame counter counts frames 0..BLINK_FRAMES-1. On its wrap, `blink_phase` toggles.
- **Snapshot:** on the tick edge where sel and phase both become 0, latch digits, dp_in, blink_mask, lz_blank and brightness into shadow registers. Only shadow values drive outputs.
- **Leading-zero blanking:** digit i (i ≥ 1) is blanked when shadow lz_blank = 1 and digits i..NUM_DIGITS-1 are all 0. Digit 0 is never LZ-blanked.
  - An LZ-blanked digit still shows its dp.
- **Digit lit** when all of the following hold:
  - en = 1
  - 1 ≤ phase ≤ shadow brightness (phase 0 is the anti-ghost dead slot)
  - not (blink_mask[sel] and blink_phase = 1)
- When lit: an = ~(1<<sel), seg = glyph (blank if LZ-blanked), dp = ~dp_in[sel]. Otherwise an = all 1, seg = 7'h7F, dp = 1.
- **en low:** prescaler, phase, sel and frame counter hold. Outputs go dark on the next edge. Scan resumes from the held state when en returns.
- **Reset:** counters, blink_phase and shadows clear to 0, so shadow brightness = 0 and the display stays dark until the first snapshot.
- **Reset values:** an = all 1, seg = 7'h7F, dp = 1, frame_start = 0.
- **Mid-operation reset:** outputs go dark immediately (asynchronous), with no partial frame afterward.

## Timing
- Slot = 8·SUB_DIV cycles; frame = NUM_DIGITS slots.
- an, seg, dp and frame_start are registered. They reflect the (sel, phase, shadow) state one cycle after that state updates.
- frame_start is high during the first output cycle of sel = 0, phase = 0, which is always dark.
- Lit time per slot = brightness·SUB_DIV cycles, contiguous, starting at phase 1.
- Input changes mid-frame are invisible until the next frame_start.
- A snapshot and a blink toggle on the same edge are both applied to the new frame.

## Structure
- Package `sevenseg_pkg` holds:
  - glyph constants, including SEG_BLANK = 7'h7F and SEG_DASH;
  - function `glyph(nibble, hex_mode)`;
  - localparam helper for SUB_DIV.
- Natural sub-module: `sevenseg_lz_mask`, combinational, NUM_DIGITS-parametrised. Maps shadow digits + lz_blank to a per-digit blank mask.
- Top module holds the prescaler, phase/sel/frame counters, shadows and output registers.

## Test plan
Bench parameters: CLK_HZ=64, SCAN_HZ=2 (SUB_DIV=4), NUM_DIGITS=4, BLINK_FRAMES=2.
- Reset, brightness=7, digits=16'h1234, en=1 → dark through the first frame. In frame 2, digit 0 shows seg=7'h4C ('4') with an=4'b1110 for 28 of 32 cycles; an stays all 1 during each phase-0 window.
- brightness=3 → each digit lit exactly 12 cycles per 32-cycle slot. brightness=0 → an constantly 4'b1111.
- digits=16'h0070, lz_blank=1, dp_in=4'b1000 → digit 3 an low with seg=7'h7F and dp=0; digit 2 blank with dp=1; digits 1 and 0 show '7' and '0'.
- blink_mask=4'b0001 → digit 0 visible for 2 frames (256 cycles), then dark for 2 frames; other digits unaffected.
- HEX_MODE=0, nibble 0xA → seg=7'h7E; nibble 0xC → seg=7'h7F. HEX_MODE=1, nibble 0xC → 'C' glyph.
- en low mid-slot for 50 cycles → outputs dark one cycle later, no frame_start pulses; phase/sel resume unchanged. Then rst_n low mid-lit → an=4'b1111 with no clock edge.
